// File: rtl/spi_rr_sched.sv
// Round-robin arbiter sharing one SPI master among N clients; grant to m_st is 1 cycle, done/err 1 cycle after LOAD rises or timeout.
// Clients hold req until their done/err pulse; no new frame starts until the master shows LOAD high while idle.
module spi_rr_sched #(
  parameter int M      = 9,
  parameter int N      = 4,
  parameter int TO_CYC = 1023
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*M-1:0] tx_dat,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic [N-1:0]   err,
  output logic [M-1:0]   rx_dat,
  output logic           busy,
  output logic           m_st,
  output logic [M-1:0]   m_tx_dat,
  input  logic [M-1:0]   m_rx_dat,
  input  logic           m_load
);

  localparam int CW = $clog2(TO_CYC + 1);
  localparam int PW = $clog2(N);

  typedef enum logic [2:0] {IDLE, START, WAIT_LO, WAIT_HI, DONE} state_t;

  state_t         r_state;
  state_t         w_nxt;
  logic [PW-1:0]  r_ptr;
  logic [PW-1:0]  r_gidx;
  logic [N-1:0]   r_gnt;
  logic [M-1:0]   r_tx;
  logic [M-1:0]   r_rx;
  logic [CW-1:0]  r_cnt;
  logic           r_err;
  logic           w_found;
  logic [PW-1:0]  w_win;
  logic           w_to;
  int             w_idx;

  // First requester at or above ptr, wrapping at N (N need not be a power of two).
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!w_found && req[w_idx[PW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[PW-1:0];
      end
    end
  end

  // Expires on the cycle the counter steps onto TO_CYC, so err lands TO_CYC+1 cycles after m_st.
  assign w_to = (r_cnt == CW'(TO_CYC - 1));

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (w_found && m_load) w_nxt = START;
      START:   w_nxt = WAIT_LO;
      WAIT_LO: if (!m_load) w_nxt = WAIT_HI;
               else if (w_to) w_nxt = DONE;
      WAIT_HI: if (m_load || w_to) w_nxt = DONE;
      DONE:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr  <= '0;
      r_gidx <= '0;
      r_gnt  <= '0;
      r_tx   <= '0;
      r_rx   <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_found && m_load) begin
          r_gnt  <= {{(N-1){1'b0}}, 1'b1} << w_win;
          r_gidx <= w_win;
          r_tx   <= tx_dat[int'(w_win)*M +: M];
          r_err  <= 1'b0;
        end
        START: r_cnt <= '0;
        WAIT_LO: begin
          if (!m_load) r_cnt <= '0;
          else begin
            if (w_to) r_err <= 1'b1;
            if (r_cnt != CW'(TO_CYC)) r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT_HI: begin
          if (m_load) r_rx <= m_rx_dat;
          else begin
            if (w_to) r_err <= 1'b1;
            if (r_cnt != CW'(TO_CYC)) r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_gnt <= '0;
          r_ptr <= (r_gidx == PW'(N - 1)) ? '0 : r_gidx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign done     = (r_state == DONE && !r_err) ? r_gnt : '0;
  assign err      = (r_state == DONE &&  r_err) ? r_gnt : '0;
  assign rx_dat   = r_rx;
  assign busy     = (r_state != IDLE);
  assign m_st     = (r_state == START);
  assign m_tx_dat = r_tx;

endmodule

// File: doc/spi_rr_sched.md
Name: spi_rr_sched

Overview:
Round-robin scheduler that shares one SPI_MASTER among N requesters. It latches the winning requester's transmit word and issues the single-cycle start pulse to the master. It then tracks the master's LOAD line to detect the end of the frame and returns the received word with a one-cycle done strobe. It sits between the client logic and SPI_MASTER; the master's MOSI, SCLK and LOAD pins pass to the slave unchanged.

Parameters:
M, 9, SPI frame width in bits; must match the master's frame width.
N, 4, number of requesters (2..8).
TO_CYC, 1023, watchdog limit in clk cycles per phase (LOAD fall, LOAD rise); must be at least 1.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-high reset.
req  in  N  request bit per requester; level-held until that requester's done or err pulse.
tx_dat  in  N*M  transmit words; requester i uses bits [i*M +: M].
gnt  out  N  one-hot grant; held from acceptance until the end of the DONE state.
done  out  N  one-cycle pulse to the granted requester; rx_dat is valid in the same cycle.
err  out  N  one-cycle pulse to the granted requester when the watchdog expires.
rx_dat  out  M  received word; holds its value until the next done.
busy  out  1  high in every state except IDLE.
m_st  out  1  start pulse to the SPI_MASTER st input.
m_tx_dat  out  M  to SPI_MASTER MTX_DAT; registered.
m_rx_dat  in  M  from SPI_MASTER MRX_DAT.
m_load  in  1  from SPI_MASTER LOAD; high = idle, low = frame in progress.

Behaviour:
- Reset values:
  - gnt, done, err, rx_dat, m_tx_dat = 0.
  - m_st = 0, busy = 0.
  - FSM = IDLE, round-robin pointer ptr = 0, watchdog counter = 0.
- FSM states: IDLE, START, WAIT_LO, WAIT_HI, DONE.
- IDLE, entry when req != 0:
  - Select the first set req bit searching from index ptr upward, wrapping modulo N.
  - Register gnt as one-hot for the winner.
  - Latch m_tx_dat from the winner's slice of tx_dat.
  - Go to START.
- START:
  - m_st = 1 for exactly this one cycle.
  - Clear the watchdog counter.
  - Go to WAIT_LO.
- WAIT_LO:
  - Wait for m_load = 0, then go to WAIT_HI and clear the watchdog counter.
  - If the watchdog counter reaches TO_CYC first, go to DONE with the error flag set.
- WAIT_HI:
  - Wait for m_load = 1; on that cycle latch rx_dat from m_rx_dat and go to DONE.
  - If the watchdog counter reaches TO_CYC first, go to DONE with the error flag set; rx_dat is not updated.
- DONE (one cycle):
  - Pulse done[g] (or err[g] if the error flag is set) for granted index g.
  - Set ptr = (g+1) mod N.
  - Clear gnt and go to IDLE.
- Latency: grant to m_st = 1 cycle. With an immediate LOAD fall, the minimum time from req to done is 4 cycles plus the frame time.
- Inputs during a frame:
  - req changes while busy are ignored.
  - tx_dat is sampled only in IDLE.
  - A requester that drops req mid-frame still receives its done pulse.
- Back-to-back: a requester re-asserting req in the done cycle competes in the next IDLE, with ptr already advanced.
- Simultaneous requests: round-robin guarantees no starvation. Any continuously requesting client is served within N grants.
- Single requester: the same requester may be granted every round; IDLE lasts at least 1 cycle between frames.
- No overlap: m_st is never asserted while m_load = 0.
- Reset mid-frame: all outputs clear immediately and the FSM goes to IDLE. The master may still finish its frame; the scheduler does not start a new frame until it has seen m_load = 1 in IDLE.
- Width rules:
  - Watchdog counter is clog2(TO_CYC+1) bits and saturates at TO_CYC.
  - ptr is clog2(N) bits; wrap is explicit for non-power-of-2 N.

Test Plan:
- Single requester: N=4, req=0001, tx slice0=9'h17A; bench master model echoes 9'h1DB. Required: m_st one cycle after grant, m_tx_dat=9'h17A, done=0001 with rx_dat=9'h1DB, then busy=0.
- Contention: req=1111 held from reset. Required: grant order 0,1,2,3,0 across five frames, exactly one done per frame.
- Pointer wrap: ptr=3 (after serving 2), req=1001. Required: grant 3 then 0.
- Watchdog: m_load stuck at 1, TO_CYC=15. Required: err pulses for the granted bit 16 cycles after m_st, done stays 0, rx_dat unchanged, next grant proceeds.
- Reset mid-frame: assert rst during WAIT_HI. Required: gnt, busy and m_st are 0 immediately. After rst release with req=0010, no m_st until the model raises m_load; then a normal frame completes.
- Req drop: requester 2 deasserts req during WAIT_LO. Required: done[2] still pulses at the end of the frame, and ptr advances to 3.
